// File: rtl/q3_pkg.sv
// Shared definitions for the q3 serial transmitter slice.
// State encoding, line levels and width helpers.
package q3_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // A one-clock bit still needs a 1-bit counter.
  function automatic int tmr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/q3_bit_timer.sv
// Per-bit clock divider for the q3 transmitter.
// tick marks the last clock of every serial bit.
module q3_bit_timer
  import q3_pkg::*;
#(
  parameter int BIT_CYCLES = 1
) (
  input  logic c,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int TW = tmr_w(BIT_CYCLES);
  localparam logic [TW-1:0] LAST = TW'(BIT_CYCLES - 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/q3_serial_tx.sv
// Parallel-in serial-out frame transmitter feeding q3 receivers.
// Frame: start, data LSB-first, optional parity, stop.
module q3_serial_tx
  import q3_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 1,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              c,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              out,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  state_t              state_q;
  state_t              state_d;
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       cnt_d;
  logic [DATA_W-1:0]   sh_q;
  logic [DATA_W-1:0]   sh_d;
  logic                par_q;
  logic                par_d;
  logic                out_q;
  logic                out_d;
  logic                rdy_q;
  logic                rdy_d;
  logic                busy_q;
  logic                busy_d;
  logic                done_q;
  logic                done_d;
  logic                accept;
  logic                tick;

  assign accept    = din_valid & rdy_q;
  assign din_ready = rdy_q;
  assign out       = out_q;
  assign busy      = busy_q;
  assign done      = done_q;

  q3_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_tmr (
    .c    (c),
    .rst_n(rst_n),
    .clr  (accept),
    .en   (busy_q),
    .tick (tick)
  );

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      out_q   <= IDLE_LEVEL;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      out_q   <= out_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = START;
      START:   if (tick) state_d = DATA;
      DATA: begin
        if (tick && cnt_q == LAST) begin
          state_d = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY:  if (tick) state_d = STOP;
      STOP:    if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so the line
  // changes on the same edge as the state.
  always_comb begin
    sh_d  = sh_q;
    par_d = par_q;
    cnt_d = cnt_q;
    if (accept) begin
      sh_d  = din;
      par_d = (^din) ^ (PARITY_ODD != 0);
      cnt_d = '0;
    end else if (state_q == DATA && tick) begin
      sh_d  = sh_q >> 1;
      cnt_d = cnt_q + 1'b1;
    end
    out_d = IDLE_LEVEL;
    unique case (state_d)
      IDLE:    out_d = IDLE_LEVEL;
      START:   out_d = START_LEVEL;
      DATA:    out_d = sh_d[0];
      PARITY:  out_d = par_d;
      STOP:    out_d = STOP_LEVEL;
      default: out_d = IDLE_LEVEL;
    endcase
    rdy_d  = (state_d == IDLE);
    busy_d = (state_d != IDLE);
    done_d = (state_q == STOP) && tick;
  end

endmodule

// File: tb/tb_q3_serial_tx.sv
// Bench for q3_serial_tx over four parameter sets.
// Expected line levels come from a per-frame bit-list model.
module tb_q3_serial_tx;

  logic       c;
  logic       rst_n;
  logic [7:0] din [4];
  logic       vld [4];
  logic       rdy [4];
  logic       so  [4];
  logic       bsy [4];
  logic       dn  [4];
  int         n_chk;
  int         n_fail;

  // 0: defaults, 1: 3 clocks/bit, 2: odd parity, 3: no parity
  for (genvar g = 0; g < 4; g++) begin : g_dut
    q3_serial_tx #(
      .DATA_W    (8),
      .BIT_CYCLES((g == 1) ? 3 : 1),
      .PARITY_EN ((g == 3) ? 0 : 1),
      .PARITY_ODD((g == 2) ? 1 : 0)
    ) u_dut (
      .c        (c),
      .rst_n    (rst_n),
      .din      (din[g]),
      .din_valid(vld[g]),
      .din_ready(rdy[g]),
      .out      (so[g]),
      .busy     (bsy[g]),
      .done     (dn[g])
    );
  end

  initial begin
    c = 1'b0;
    forever #5 c = ~c;
  end

  // Entered in cycle 1 of a frame; returns in its done cycle.
  task automatic check_frame(input int idx, input logic [7:0] w,
                             input bit keep, input int sw_at,
                             input logic [7:0] sw_val);
    bit   lv[$];
    int   bc;
    logic p;
    bc = (idx == 1) ? 3 : 1;
    p  = (^w) ^ (idx == 2);
    repeat (bc) lv.push_back(1'b0);
    for (int b = 0; b < 8; b++) begin
      repeat (bc) lv.push_back(w[b]);
    end
    if (idx != 3) begin
      repeat (bc) lv.push_back(p);
    end
    repeat (bc) lv.push_back(1'b1);
    if (!keep) vld[idx] = 1'b0;
    foreach (lv[i]) begin
      if (i == sw_at) din[idx] = sw_val;
      n_chk++;
      if (so[idx] !== lv[i] || bsy[idx] !== 1'b1 ||
          dn[idx] !== 1'b0 || rdy[idx] !== 1'b0) begin
        n_fail++;
        $display("FAIL frame u%0d w=%h cyc %0d: out/busy/done/rdy=%b%b%b%b required %b100",
                 idx, w, i + 1, so[idx], bsy[idx], dn[idx], rdy[idx], lv[i]);
      end
      @(negedge c);
    end
    n_chk++;
    if (dn[idx] !== 1'b1 || bsy[idx] !== 1'b0 ||
        rdy[idx] !== 1'b1 || so[idx] !== 1'b1) begin
      n_fail++;
      $display("FAIL done u%0d w=%h: done/busy/rdy/out=%b%b%b%b required 1011",
               idx, w, dn[idx], bsy[idx], rdy[idx], so[idx]);
    end
  endtask

  task automatic send(input int idx, input logic [7:0] w);
    n_chk++;
    if (rdy[idx] !== 1'b1) begin
      n_fail++;
      $display("FAIL ready u%0d: din_ready=%b required 1", idx, rdy[idx]);
    end
    din[idx] = w;
    vld[idx] = 1'b1;
    @(negedge c);
    check_frame(idx, w, 1'b0, -1, 8'h00);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din[i] = 8'h00;
      vld[i] = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (so[i] !== 1'b1 || rdy[i] !== 1'b1 ||
          bsy[i] !== 1'b0 || dn[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset u%0d: out/rdy/busy/done=%b%b%b%b required 1100",
                 i, so[i], rdy[i], bsy[i], dn[i]);
      end
    end
    repeat (2) @(negedge c);
    rst_n = 1'b1;
    @(negedge c);
  endtask

  task automatic test_default();
    send(0, 8'hA5);
    send(0, 8'h5A);
  endtask

  task automatic test_bit_cycles();
    send(1, 8'h01);
    repeat (3) send(1, 8'($urandom));
  endtask

  task automatic test_parity();
    send(2, 8'h00);
    send(3, 8'hFF);
    repeat (3) send(2, 8'($urandom));
    repeat (3) send(3, 8'($urandom));
  endtask

  task automatic test_random();
    int idx;
    repeat (20) begin
      idx = $urandom_range(0, 3);
      send(idx, 8'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge c);
    end
  endtask

  task automatic test_back_to_back();
    n_chk++;
    if (rdy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b ready: din_ready=%b required 1", rdy[0]);
    end
    din[0] = 8'h11;
    vld[0] = 1'b1;
    @(negedge c);
    check_frame(0, 8'h11, 1'b1, 4, 8'h22);
    @(negedge c);
    check_frame(0, 8'h22, 1'b0, -1, 8'h00);
  endtask

  task automatic test_reset_mid();
    logic [7:0] w;
    w = 8'hC3;
    din[0] = w;
    vld[0] = 1'b1;
    @(negedge c);
    vld[0] = 1'b0;
    repeat (5) @(negedge c);
    n_chk++;
    if (so[0] !== w[4] || bsy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL bit4 before reset: out/busy=%b%b required %b1",
               so[0], bsy[0], w[4]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (so[0] !== 1'b1 || bsy[0] !== 1'b0 ||
        rdy[0] !== 1'b1 || dn[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL async reset: out/busy/rdy/done=%b%b%b%b required 1010",
               so[0], bsy[0], rdy[0], dn[0]);
    end
    repeat (2) @(negedge c);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge c);
      n_chk++;
      if (dn[0] !== 1'b0 || so[0] !== 1'b1 || bsy[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL after reset: done/out/busy=%b%b%b required 010",
                 dn[0], so[0], bsy[0]);
      end
    end
    send(0, 8'h3C);
  endtask

  task automatic test_idle();
    for (int i = 0; i < 4; i++) vld[i] = 1'b0;
    repeat (50) begin
      @(negedge c);
      for (int i = 0; i < 4; i++) begin
        n_chk++;
        if (so[i] !== 1'b1 || bsy[i] !== 1'b0 || dn[i] !== 1'b0) begin
          n_fail++;
          $display("FAIL idle u%0d: out/busy/done=%b%b%b required 100",
                   i, so[i], bsy[i], dn[i]);
        end
      end
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_default();
    test_bit_cycles();
    test_parity();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_idle();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
